// File: rtl/riscv_pkg.sv
// Shared core types: XLEN, canonical NOP and the fetch packet
// that travels from IF to ID.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: in-order FIFO of fetch packets,
// emptied on reset or control-flow redirect.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_pkt_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;
    fetch_pkt_t      head;

    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt_q;
    assign head      = mem_q[rd_q];

    // Empty queue drives a NOP so decode never sees stale storage
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            if (push && !pop) cnt_d = cnt_q + CW'(1);
            if (pop && !push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem_q[wr_q] <= '{pc: in_pc, instr: in_instr};
        end
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage (IF) and decode (ID). Fetch pushes {pc, instr} packets through a valid/ready handshake. Decode pops them in order and feeds the instruction word to the decoder and immediate generator. The queue absorbs decode stalls without back-pressuring the fetch PC every cycle, and it discards all contents on a control-flow redirect (flush).

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥2
- XLEN, 32: PC width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- flush  in  1  redirect from branch/jump resolution; empties the queue
- in_valid  in  1  fetch presents a packet
- in_ready  out  1  queue accepts a packet this cycle
- in_pc  in  XLEN  PC of the fetched instruction
- in_instr  in  32  fetched instruction word
- out_valid  out  1  head packet is valid
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  XLEN  PC of the head packet
- out_instr  out  32  head instruction word
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH

## Operation
- **State:**
  - storage array of DEPTH packets
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0
  - count register
- **Handshake rules:**
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (count != DEPTH). It never depends on out_ready, so there is no combinational path from in_ready to out_ready.
  - out_valid = (count != 0)
- **Head output:** out_pc and out_instr read storage[rd_ptr] combinationally from registered state.
  - When the queue is empty, out_instr = NOP (32'h0000_0013) and out_pc = 0.
  - Decode and the immediate generator therefore never see stale data.
- **Per-cycle update**, in priority order:
  1. reset: wr_ptr = rd_ptr = count = 0.
  2. flush: wr_ptr = rd_ptr = count = 0. Any push or pop in the same cycle is discarded; fetch must re-present the packet from the redirected PC.
  3. push only: write storage[wr_ptr], wr_ptr+1, count+1.
  4. pop only: rd_ptr+1, count-1.
  5. push and pop together: write, both pointers advance, count unchanged. Legal at any count 1..DEPTH-1. At count==DEPTH, in_ready is 0, so only the pop occurs.
- Storage contents are not reset; only pointers and count are.
- **No bypass:** a packet pushed into an empty queue is not visible on out_* in the same cycle.
- in_valid while in_ready=0: no state change. Fetch holds the packet stable.

## Timing
- **Reset values** (cycle after reset is sampled high):
  - in_ready=1, out_valid=0, count=0
  - out_pc=0, out_instr=32'h0000_0013
- **Latency:**
  - Push at edge N → out_valid=1 with that packet after edge N, visible in cycle N+1.
  - Throughput is one packet per cycle in steady state.
- **Full:** after the DEPTH-th push with no pop, in_ready=0 from the next cycle. A pop at full raises in_ready the following cycle; there is no same-cycle re-use of the slot.
- **Empty:** after the last pop, out_valid=0 the next cycle.
- **Flush:** effective at the edge. The next cycle has count=0, out_valid=0, in_ready=1.
- **Reset or flush mid-stream:** identical result; pointers restart at 0 regardless of their previous wrap position.

## Structure
- Shared package riscv_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - typedef fetch_pkt_t {logic [XLEN-1:0] pc; logic [31:0] instr;}
- The IF and ID stages reuse fetch_pkt_t.
- Single module, no sub-module. The storage array is an unpacked array of fetch_pkt_t inferred as flops.
- Expected size: about 150 lines.

## Test plan
- **Reset then single push:** push pc=0x100, instr=0x00500093 → next cycle out_valid=1, out_pc=0x100, out_instr=0x00500093, count=1; with out_ready=0 the outputs hold.
- **Fill to full:** push pc 0x0,0x4,0x8,0xC with out_ready=0 → count=4, in_ready=0; a 5th in_valid is not accepted; then pop 4 → PCs emerge in order 0x0..0xC, then out_valid=0 and out_instr=0x00000013.
- **Simultaneous push/pop at count=2:** count stays 2, order preserved. Run 20 cycles continuously so the pointers wrap ≥4 times; the popped PC sequence must be contiguous.
- **Flush with concurrent push and pop at count=3:** next cycle count=0, out_valid=0, in_ready=1. The packet pushed on the flush cycle never appears on out_*.
- **Reset asserted mid-stream at count=2:** next cycle all outputs at reset values. The following push of pc=0x200 appears at the head with no remnants of earlier packets.
- **Random valid/ready scoreboard:** 10k cycles with random in_valid, out_ready and flush at 2% → every popped packet matches the reference-model FIFO; count never exceeds DEPTH.
